// File: rtl/memory_stage_pkg.sv
// Shared types for the memory stage: bus access sizes, FSM states, pipeline status
// and forwarding records. Lane-select helpers live here so the bench can reuse names.
package memory_access;
  typedef enum logic [1:0] {BYTE, HALF, WORD} size_t;
  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  // Half and word accesses snap to their natural boundary.
  function automatic logic [1:0] eff_offset(size_t size, logic [1:0] a);
    case (size)
      BYTE:    return a;
      HALF:    return {a[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lane_select(size_t size, logic [1:0] a);
    case (size)
      BYTE:    return 4'b0001 << a;
      HALF:    return 4'b0011 << a;
      default: return 4'b1111;
    endcase
  endfunction
endpackage

package pipeline_status;
  typedef enum logic [2:0] {BUBBLE = 3'd0, VALID, MISALIGNED_LOAD, MISALIGNED_STORE} forwards_t;
  typedef enum logic [1:0] {READY = 2'd0, STALL, JUMP} backwards_t;
endpackage

package instruction;
  typedef struct packed {
    logic [4:0]            rd_address;
    logic                  rd_write;
    logic                  load;
    logic                  store;
    memory_access::size_t  size;
    logic                  mem_unsigned;
  } t;
endpackage

package forwarding;
  typedef struct packed {
    logic        valid;
    logic [4:0]  rd_address;
    logic [31:0] data;
  } t;
endpackage

// File: rtl/memory_stage_load_aligner.sv
// Combinational load alignment: shift the read word down to the accessed lane,
// then sign- or zero-extend to 32 bits.
module load_aligner
  import memory_access::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_offset,
  input  size_t       i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);
  logic [31:0] w_shifted;

  assign w_shifted = i_rdata >> {i_offset, 3'b000};

  always_comb begin
    o_data = w_shifted;
    case (i_size)
      BYTE:    o_data = {{24{~i_unsigned & w_shifted[7]}}, w_shifted[7:0]};
      HALF:    o_data = {{16{~i_unsigned & w_shifted[15]}}, w_shifted[15:0]};
      default: o_data = w_shifted;
    endcase
  end
endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: single-outstanding load/store bus master with result register.
// Optional MEMORY_STAGE_MISALIGN_TRAP_EN turns misaligned half/word accesses into traps.
module memory_stage
  import memory_access::*;
  import pipeline_status::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   source_data_in,
  input  logic [31:0]   rd_data_in,
  input  instruction::t instruction_in,
  input  logic [31:0]   program_counter_in,
  input  logic [31:0]   next_program_counter_in,
  output logic [31:0]   rd_data_reg_out,
  output instruction::t instruction_reg_out,
  output logic [31:0]   program_counter_reg_out,
  output logic [31:0]   next_program_counter_reg_out,
  output forwarding::t  forwarding_out,
  input  forwards_t     status_forwards_in,
  output forwards_t     status_forwards_out,
  input  backwards_t    status_backwards_in,
  output backwards_t    status_backwards_out,
  input  logic [31:0]   jump_address_backwards_in,
  output logic [31:0]   jump_address_backwards_out,
  output logic          mem_req_out,
  output logic          mem_we_out,
  output logic [31:0]   mem_addr_out,
  output logic [3:0]    mem_sel_out,
  output logic [31:0]   mem_wdata_out,
  input  logic          mem_ack_in,
  input  logic [31:0]   mem_rdata_in
);
  state_t      r_state;
  logic        r_jump_pending;
  logic [31:0] r_rdata;

  logic        w_is_mem, w_misaligned, w_access, w_start, w_req;
  logic        w_wait_stall, w_ds_stall, w_advance;
  logic [1:0]  w_offset;
  logic [31:0] w_load_data, w_result, w_wdata;
  forwards_t   w_status_next;

  assign w_is_mem = (status_forwards_in == VALID) && (instruction_in.load || instruction_in.store);

`ifdef MEMORY_STAGE_MISALIGN_TRAP_EN
  assign w_misaligned = w_is_mem &&
    ((instruction_in.size == HALF && rd_data_in[0]) ||
     (instruction_in.size == WORD && rd_data_in[1:0] != 2'b00));
`else
  assign w_misaligned = 1'b0;
`endif

  assign w_access = w_is_mem && !w_misaligned;
  // A fresh access is not launched under JUMP: it is wrong-path and a store would be irreversible.
  assign w_start  = w_access && (status_backwards_in != JUMP);
  assign w_offset = eff_offset(instruction_in.size, rd_data_in[1:0]);

  assign w_req        = rst && ((r_state == IDLE && w_start) || r_state == WAIT);
  assign w_wait_stall = w_req && !mem_ack_in;
  assign w_ds_stall   = (status_backwards_in == STALL);
  assign w_advance    = !w_ds_stall && !w_wait_stall;

  always_comb begin
    w_wdata = source_data_in;
    case (instruction_in.size)
      BYTE:    w_wdata = {4{source_data_in[7:0]}};
      HALF:    w_wdata = {2{source_data_in[15:0]}};
      default: w_wdata = source_data_in;
    endcase
  end

  assign mem_req_out   = w_req;
  assign mem_we_out    = w_req && instruction_in.store;
  assign mem_addr_out  = w_req ? {rd_data_in[31:2], 2'b00} : 32'h0;
  assign mem_sel_out   = w_req ? lane_select(instruction_in.size, w_offset) : 4'b0000;
  assign mem_wdata_out = (w_req && instruction_in.store) ? w_wdata : 32'h0;

  load_aligner u_load_aligner (
    .i_rdata    ((r_state == HOLD) ? r_rdata : mem_rdata_in),
    .i_offset   (w_offset),
    .i_size     (instruction_in.size),
    .i_unsigned (instruction_in.mem_unsigned),
    .o_data     (w_load_data)
  );

  assign w_result = w_misaligned ? rd_data_in :
                    (w_access && instruction_in.load) ? w_load_data : rd_data_in;

  // While our own access is pending and downstream is free, feed it bubbles so nothing repeats.
  always_comb begin
    w_status_next = status_forwards_in;
    if (status_backwards_in == JUMP || r_jump_pending || w_wait_stall)
      w_status_next = BUBBLE;
    else if (w_misaligned)
      w_status_next = instruction_in.load ? MISALIGNED_LOAD : MISALIGNED_STORE;
  end

  assign status_backwards_out       = (w_wait_stall || w_ds_stall) ? STALL : status_backwards_in;
  assign jump_address_backwards_out = jump_address_backwards_in;

  assign forwarding_out.valid      = (status_forwards_out == VALID) && instruction_reg_out.rd_write;
  assign forwarding_out.rd_address = instruction_reg_out.rd_address;
  assign forwarding_out.data       = rd_data_reg_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state                      <= IDLE;
      r_jump_pending               <= 1'b0;
      r_rdata                      <= 32'h0;
      status_forwards_out          <= BUBBLE;
      rd_data_reg_out              <= 32'h0;
      instruction_reg_out          <= '0;
      program_counter_reg_out      <= 32'h0;
      next_program_counter_reg_out <= 32'h0;
    end else begin
      case (r_state)
        IDLE:    if (w_req) begin
                   if (!mem_ack_in)     r_state <= WAIT;
                   else if (w_ds_stall) r_state <= HOLD;
                 end
        WAIT:    if (mem_ack_in) r_state <= w_ds_stall ? HOLD : IDLE;
        HOLD:    if (!w_ds_stall) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
      if (w_req && mem_ack_in)
        r_rdata <= mem_rdata_in;
      // A JUMP seen mid-access lets the bus cycle finish but discards its result.
      if (status_backwards_in == JUMP && w_wait_stall)
        r_jump_pending <= 1'b1;
      else if (w_advance)
        r_jump_pending <= 1'b0;
      if (!w_ds_stall)
        status_forwards_out <= w_status_next;
      if (w_advance) begin
        rd_data_reg_out              <= w_result;
        instruction_reg_out          <= instruction_in;
        program_counter_reg_out      <= program_counter_in;
        next_program_counter_reg_out <= next_program_counter_in;
      end
    end
  end
endmodule
